// File: rtl/slowfil_feeder.sv
// Feeder for a slow (time-multiplexed) FIR filter.
// On i_load it resets the filter, streams NTAPS coefficients into it,
// and then paces incoming samples so that consecutive filter strobes
// are at least NTAPS+1 cycles apart. The filter needs that many cycles
// to work through its taps for each sample.
module slowfil_feeder #(
  parameter int               LGNTAPS = 7,
  parameter logic [LGNTAPS:0] NTAPS   = 110,
  parameter int               IW      = 16,
  parameter int               TW      = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic          i_coef_valid,
  output logic          o_coef_ready,
  input  logic [TW-1:0] i_coef,
  input  logic          i_sample_valid,
  output logic          o_sample_ready,
  input  logic [IW-1:0] i_sample,
  output logic          o_fil_reset,
  output logic          o_tap_wr,
  output logic [TW-1:0] o_tap,
  output logic          o_ce,
  output logic [IW-1:0] o_sample,
  output logic          o_running
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_LOAD  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [LGNTAPS:0] coef_cnt;
  logic [LGNTAPS:0] gap;
  logic             coef_hs;
  logic             sample_hs;
  logic             last_coef;

  assign coef_hs   = i_coef_valid && o_coef_ready;
  assign sample_hs = i_sample_valid && o_sample_ready;
  assign last_coef = (coef_cnt == NTAPS - 1'b1);

  // State register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of the order of the blocks.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state logic: i_load restarts the sequence from any state.
  // NOTE: next_state gets a default before the case, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    if (i_load) begin
      next_state = S_FLUSH;
    end else begin
      case (state)
        S_IDLE:  next_state = S_IDLE;
        S_FLUSH: next_state = S_LOAD;
        S_LOAD:  if (coef_hs && last_coef) next_state = S_RUN;
        S_RUN:   next_state = S_RUN;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Handshake readies. A same-cycle i_load wins over either stream.
  always_comb begin
    o_coef_ready   = (state == S_LOAD) && !i_load;
    o_sample_ready = (state == S_RUN) && (gap == '0) && !i_load;
  end

  // Coefficient counter: restarts on every flush, counts accepted taps.
  always_ff @(posedge i_clk) begin
    if (i_reset)                 coef_cnt <= '0;
    else if (state == S_FLUSH)   coef_cnt <= '0;
    else if (coef_hs)            coef_cnt <= coef_cnt + 1'b1;
  end

  // Gap counter: blocks sample acceptance for NTAPS cycles after a sample.
  always_ff @(posedge i_clk) begin
    if (i_reset)                                      gap <= '0;
    else if (state == S_LOAD && next_state == S_RUN)  gap <= '0;
    else if (sample_hs)                               gap <= NTAPS;
    else if (gap != '0)                               gap <= gap - 1'b1;
  end

  // Registered filter-side outputs; data words hold between strobes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_fil_reset <= 1'b0;
      o_running   <= 1'b0;
      o_tap_wr    <= 1'b0;
      o_tap       <= '0;
      o_ce        <= 1'b0;
      o_sample    <= '0;
    end else begin
      o_fil_reset <= (next_state == S_FLUSH);
      o_running   <= (next_state == S_RUN);
      o_tap_wr    <= coef_hs;
      o_ce        <= sample_hs;
      if (coef_hs)   o_tap    <= i_coef;
      if (sample_hs) o_sample <= i_sample;
    end
  end

endmodule
